// File: rtl/mem_port_arb.sv
// Shares one variable-latency memory port between instruction fetch and load/store.
// Data has priority; a streak counter guarantees fetch progress and a timeout turns a hung access into an error.
module mem_port_arb #(
    parameter int TIMEOUT         = 255,
    parameter int FETCH_GUARANTEE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ready,
    input  logic [31:0] m_rdata
);

    localparam int SW = (FETCH_GUARANTEE < 1) ? 1 : $clog2(FETCH_GUARANTEE + 1);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX  = SW'(FETCH_GUARANTEE);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcnt;

    logic if_cand;
    logic d_cand;
    logic grant_if;
    logic grant_d;
    logic finish;

    function automatic logic [SW-1:0] streak_step(input logic [SW-1:0] v);
        return (v >= STREAK_MAX) ? STREAK_MAX : v + 1'b1;
    endfunction

    // A requester completing this cycle is masked so it can drop req alongside its done.
    always_comb begin
        if_cand  = if_req && !if_done;
        d_cand   = d_req && !d_done;
        grant_d  = d_cand && !(if_cand && (streak == STREAK_MAX));
        grant_if = if_cand && !grant_d;
        finish   = m_ready || (tcnt == TIMEOUT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            streak   <= '0;
            tcnt     <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_be     <= '0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            err      <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state   <= BUSY_D;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_be    <= d_be;
                        tcnt    <= '0;
                        streak  <= if_req ? streak_step(streak) : '0;
                    end else if (grant_if) begin
                        state   <= BUSY_IF;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                        m_wdata <= '0;
                        m_be    <= 4'b1111;
                        tcnt    <= '0;
                        streak  <= '0;
                    end
                end
                BUSY_IF, BUSY_D: begin
                    if (finish) begin
                        // m_ready wins over an expiring timeout on the same edge.
                        if (state == BUSY_IF) begin
                            if_done  <= 1'b1;
                            if_rdata <= m_ready ? m_rdata : '0;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= m_ready ? m_rdata : '0;
                        end
                        err   <= !m_ready;
                        m_req <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_port_arb;

    localparam int TO = 8;
    localparam int FG = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_ready;
    logic [31:0] m_rdata;

    int total = 0;
    int bad   = 0;

    mem_port_arb #(.TIMEOUT(TO), .FETCH_GUARANTEE(FG)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_done(d_done), .d_rdata(d_rdata), .err(err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ready(m_ready), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who holds the port, since which edge, and how many data grants fetch has sat through.
    int          owner = 0;   // 0 free, 1 fetch, 2 data
    int          edge_n = 0;
    int          grant_edge = 0;
    int          data_run = 0;
    logic        e_m_req, e_m_we, e_if_done, e_d_done, e_err;
    logic [31:0] e_m_addr, e_m_wdata, e_if_rdata, e_d_rdata;
    logic [3:0]  e_m_be;
    bit          was_if_done, was_d_done, want_if, want_d;

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (rst) begin
            owner = 0; data_run = 0;
            e_m_req = 0; e_m_we = 0; e_m_addr = 0; e_m_wdata = 0; e_m_be = 0;
            e_if_done = 0; e_d_done = 0; e_err = 0; e_if_rdata = 0; e_d_rdata = 0;
        end else begin
            was_if_done = e_if_done;
            was_d_done  = e_d_done;
            e_if_done = 0; e_d_done = 0; e_err = 0;
            if (owner == 0) begin
                want_if = if_req && !was_if_done;
                want_d  = d_req && !was_d_done;
                if (want_d && !(want_if && data_run >= FG)) begin
                    owner = 2; grant_edge = edge_n;
                    e_m_req = 1; e_m_we = d_we; e_m_addr = d_addr; e_m_wdata = d_wdata; e_m_be = d_be;
                    data_run = if_req ? ((data_run + 1 > FG) ? FG : data_run + 1) : 0;
                end else if (want_if) begin
                    owner = 1; grant_edge = edge_n;
                    e_m_req = 1; e_m_we = 0; e_m_addr = if_addr; e_m_wdata = 0; e_m_be = 4'hF;
                    data_run = 0;
                end
            end else if (m_ready || (edge_n - grant_edge > TO)) begin
                if (owner == 1) begin
                    e_if_done = 1; e_if_rdata = m_ready ? m_rdata : 32'h0;
                end else begin
                    e_d_done = 1; e_d_rdata = m_ready ? m_rdata : 32'h0;
                end
                e_err = !m_ready;
                e_m_req = 0;
                owner = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("m_req", 32'(m_req), 32'(e_m_req));
        check("m_we", 32'(m_we), 32'(e_m_we));
        check("m_addr", m_addr, e_m_addr);
        check("m_wdata", m_wdata, e_m_wdata);
        check("m_be", 32'(m_be), 32'(e_m_be));
        check("if_done", 32'(if_done), 32'(e_if_done));
        check("d_done", 32'(d_done), 32'(e_d_done));
        check("err", 32'(err), 32'(e_err));
        if (e_if_done) check("if_rdata", if_rdata, e_if_rdata);
        if (e_d_done) check("d_rdata", d_rdata, e_d_rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        m_ready = 0; m_rdata = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_req"}, 32'(m_req), 0);
        check({tag, "_m_we"}, 32'(m_we), 0);
        check({tag, "_m_addr"}, m_addr, 0);
        check({tag, "_m_wdata"}, m_wdata, 0);
        check({tag, "_m_be"}, 32'(m_be), 0);
        check({tag, "_if_done"}, 32'(if_done), 0);
        check({tag, "_d_done"}, 32'(d_done), 0);
        check({tag, "_if_rdata"}, if_rdata, 0);
        check({tag, "_d_rdata"}, d_rdata, 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    int slow_mode;

    initial begin
        rst = 1;
        idle_inputs();
        tick();
        tick();
        check_all_zero("rst");
        rst = 0;
        tick();

        // Single fetch, zero wait states.
        if_req = 1; if_addr = 32'h100;
        tick();
        check("f_m_req", 32'(m_req), 1);
        check("f_m_addr", m_addr, 32'h100);
        check("f_m_be", 32'(m_be), 32'hF);
        check("f_m_we", 32'(m_we), 0);
        m_ready = 1; m_rdata = 32'hDEADBEEF;
        tick();
        check("f_done", 32'(if_done), 1);
        check("f_rdata", if_rdata, 32'hDEADBEEF);
        check("f_err", 32'(err), 0);
        if_req = 0; m_ready = 0;
        tick();

        // Store with three wait states.
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678; d_be = 4'b0011;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("st_m_addr", m_addr, 32'h40);
            check("st_m_wdata", m_wdata, 32'h12345678);
            check("st_m_be", 32'(m_be), 32'h3);
            check("st_m_we", 32'(m_we), 1);
            tick();
        end
        m_ready = 1;
        tick();
        check("st_d_done", 32'(d_done), 1);
        check("st_if_done", 32'(if_done), 0);
        d_req = 0; m_ready = 0;
        tick();

        // Timeout on a load, then a clean fetch.
        d_req = 1; d_we = 0; d_addr = 32'h80; d_be = 4'hF;
        tick();
        for (int i = 0; i < TO; i++) tick();
        check("to_early", 32'(d_done), 0);
        tick();
        check("to_done", 32'(d_done), 1);
        check("to_err", 32'(err), 1);
        check("to_rdata", d_rdata, 0);
        check("to_m_req", 32'(m_req), 0);
        d_req = 0; if_req = 1; if_addr = 32'h200;
        tick();
        m_ready = 1; m_rdata = 32'h0BADF00D;
        tick();
        check("to_f_done", 32'(if_done), 1);
        check("to_f_err", 32'(err), 0);
        if_req = 0; m_ready = 0;
        tick();

        // m_ready lands exactly on the timeout edge.
        d_req = 1; d_we = 0; d_addr = 32'hC0;
        tick();
        for (int i = 0; i < TO; i++) tick();
        m_ready = 1; m_rdata = 32'hCAFEF00D;
        tick();
        check("tie_done", 32'(d_done), 1);
        check("tie_err", 32'(err), 0);
        check("tie_rdata", d_rdata, 32'hCAFEF00D);
        d_req = 0; m_ready = 0;
        tick();

        // Reset in the middle of a data access.
        d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h55AA55AA; d_be = 4'hC;
        tick();
        tick();
        rst = 1;
        tick();
        check_all_zero("rmid");
        rst = 0; m_ready = 1; m_rdata = 32'h11112222;
        tick();
        check("rmid_m_req", 32'(m_req), 1);
        check("rmid_nodone", 32'(d_done), 0);
        tick();
        check("rmid_done", 32'(d_done), 1);
        d_req = 0; m_ready = 0;
        tick();

        // Both requesters held with a fast memory.
        if_req = 1; if_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2000; m_ready = 1;
        for (int i = 0; i < 24; i++) begin
            m_rdata = $urandom;
            tick();
        end
        idle_inputs();
        tick();
        tick();

        // Randomized traffic; a waiting fetch may withdraw so long data streaks can build up.
        slow_mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) slow_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            rst = ($urandom_range(0, 599) == 0);
            if (owner != 1) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (owner != 2) begin
                d_req   = ($urandom_range(0, 1) != 0);
                d_we    = $urandom_range(0, 1);
                d_addr  = $urandom & 32'hFFFF_FFFC;
                d_wdata = $urandom;
                d_be    = 4'($urandom);
            end
            m_ready = slow_mode ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
            m_rdata = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
